// File: rtl/soc_uart_pkg.sv
// Shared definitions for the SoC byte-output UART: FSM encoding and frame geometry.
package soc_uart_pkg;

  // FSM state encoding (2 bits)
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  // Payload bits per frame; a full 8N1 frame adds one start and one stop bit
  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;

endpackage

// File: rtl/soc_byte_fifo.sv
// Small synchronous byte FIFO. Head entry is presented combinationally on dout.
// A push into a full FIFO is only taken when a pop happens on the same edge.
module soc_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy; pointers wrap naturally
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_ok   = pop && !empty;
    push_ok  = push && (!full || pop_ok);
    if (push_ok) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer/occupancy registers; reset discards contents by zeroing the count
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/soc_uart_tx.sv
// 8N1 UART transmitter fed by the SoC byte-output port. There is no backpressure:
// bytes that arrive while the FIFO is full (and not popping) are dropped and
// recorded in a sticky overflow flag.
module soc_uart_tx
  import soc_uart_pkg::*;
#(
  parameter int CLK_DIV    = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  input  logic                          clr_overflow,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLK_DIV - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             ovf_q, ovf_d;

  logic             pop;
  logic             bit_end;
  logic             fifo_full, fifo_empty;
  logic [7:0]       fifo_dout;

  soc_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (in_valid),
    .din    (in_byte),
    .pop    (pop),
    .dout   (fifo_dout),
    .count  (fifo_count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign bit_end  = (baud_q == '0);
  assign txd      = txd_q;
  assign overflow = ovf_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

  // Frame sequencer: every bit lasts CLK_DIV cycles, and the end of STOP
  // chains straight into the next START when more bytes are queued
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          baud_d  = BAUD_RELOAD;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
          baud_d    = BAUD_RELOAD;
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          baud_d  = BAUD_RELOAD;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            baud_d  = BAUD_RELOAD;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          baud_d = baud_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Line level follows the current state one cycle later from a flop, so txd
  // never glitches
  always_comb begin
    txd_d = 1'b1;
    case (state_q)
      ST_START: txd_d = 1'b0;
      ST_DATA:  txd_d = shift_q[0];
      default:  txd_d = 1'b1;
    endcase
  end

  // Sticky overflow: a dropped push beats a simultaneous clear
  always_comb begin
    ovf_d = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (in_valid && fifo_full && !pop) ovf_d = 1'b1;
  end

  // State registers; reset abandons any frame in flight and idles the line
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      txd_q     <= txd_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
